ssd_mux_driver: RTL and testbench

Parametrised time-multiplexed seven-segment driver for NUM_DIGITS hex digits. Runs on the system clock. An internal prescaler sets the refresh rate and a dead-time interval suppresses ghosting between digits. Adds double-buffered data with tear-free frame updates, per-digit blank and decimal point, leading-zero blanking, and selectable segment/anode polarity. Sits between counter/status logic and the Pmod/board display pins; the 2-digit PmodSSD uses NUM_DIGITS=2 with digit_idx[0] as the select line.

---
 rtl/ssd_pkg.sv | 20 ++
 rtl/ssd_hex_to_seg.sv | 12 +
 rtl/ssd_mux_driver.sv | 188 ++++++++++++++++++
 tb/tb_ssd_mux_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment patterns are active-high, bit0=a .. bit6=g.
package ssd_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } ssd_state_e;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Index 0 is the rightmost entry: 0..9, A, b, C, d, E, F.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39,
      7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66,
      7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/ssd_hex_to_seg.sv
// Hex nibble to active-high a-g segment pattern.
// Purely combinational; pin polarity is handled by the caller.
module ssd_hex_to_seg
   import ssd_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/ssd_mux_driver.sv
// Time-multiplexed seven-segment driver with dead-time, double-buffered
// digit data, per-digit blank/dp, leading-zero blanking and pin polarity.
module ssd_mux_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS      = 2,
   parameter int REFRESH_DIV     = 50000,
   parameter int DEAD_CYCLES     = 500,
   parameter bit SEG_ACTIVE_HIGH = 1'b1,
   parameter bit AN_ACTIVE_HIGH  = 1'b1,
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lzb_en,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [IW-1:0]           digit_idx,
   output logic                    frame_start
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam int DL = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

   localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] DEAD_LAST = DW'(DL);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   localparam logic [NUM_DIGITS-1:0] AN_IDLE =
      {NUM_DIGITS{~AN_ACTIVE_HIGH}};
   localparam logic [6:0] SEG_IDLE = SEG_OFF ^ {7{~SEG_ACTIVE_HIGH}};
   localparam logic       DP_IDLE  = ~SEG_ACTIVE_HIGH;

   ssd_state_e r_state;
   ssd_state_e w_state;

   logic [PW-1:0] r_pre;
   logic [PW-1:0] w_pre;
   logic [DW-1:0] r_dead;
   logic [DW-1:0] w_dead;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] w_idx;
   logic          w_adv0;
   logic          r_frame;

   logic [4*NUM_DIGITS-1:0] r_pd_data;
   logic [NUM_DIGITS-1:0]   r_pd_dp;
   logic [NUM_DIGITS-1:0]   r_pd_blank;
   logic [4*NUM_DIGITS-1:0] r_sh_data;
   logic [NUM_DIGITS-1:0]   r_sh_dp;
   logic [NUM_DIGITS-1:0]   r_sh_blank;

   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;

   logic [NUM_DIGITS-1:0] w_dark;
   logic                  w_run;
   logic                  w_zero;
   logic [3:0]            w_nib;
   logic                  w_sel_dp;
   logic                  w_sel_dark;
   logic [NUM_DIGITS-1:0] w_onehot;
   logic                  w_lit;
   logic [6:0]            w_seg;

   always_comb begin
      w_state = r_state;
      w_pre   = r_pre;
      w_dead  = r_dead;
      w_idx   = r_idx;
      w_adv0  = 1'b0;
      if (!enable) begin
         w_state = BLANK;
         w_pre   = '0;
         w_dead  = '0;
      end else begin
         unique case (r_state)
            BLANK: begin
               if (r_dead == DEAD_LAST) begin
                  w_dead  = '0;
                  w_state = SHOW;
                  w_adv0  = (r_idx == IDX_LAST);
                  w_idx   = w_adv0 ? '0 : r_idx + 1'b1;
               end else begin
                  w_dead = r_dead + 1'b1;
               end
            end
            SHOW: begin
               if (r_pre == PRE_LAST) begin
                  w_pre   = '0;
                  w_state = BLANK;
               end else begin
                  w_pre = r_pre + 1'b1;
               end
            end
         endcase
      end
   end

   // Scan from the top digit: w_run stays set while every higher digit is
   // zero or blanked and no decimal point has been seen.
   always_comb begin
      w_run  = 1'b1;
      w_zero = 1'b0;
      w_dark = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         w_zero    = (r_sh_data[4*k +: 4] == 4'h0);
         w_dark[k] = r_sh_blank[k] |
                     (lzb_en & w_run & w_zero & (k != 0) & ~r_sh_dp[k]);
         w_run     = w_run & (w_zero | r_sh_blank[k]) & ~r_sh_dp[k];
      end
   end

   always_comb begin
      w_nib      = '0;
      w_sel_dp   = 1'b0;
      w_sel_dark = 1'b1;
      w_onehot   = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_nib       = r_sh_data[4*k +: 4];
            w_sel_dp    = r_sh_dp[k];
            w_sel_dark  = w_dark[k];
            w_onehot[k] = 1'b1;
         end
      end
      w_lit = (r_state == SHOW) & ~w_sel_dark;
   end

   ssd_hex_to_seg u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= BLANK;
         r_pre      <= '0;
         r_dead     <= '0;
         r_idx      <= IDX_LAST;
         r_frame    <= 1'b0;
         r_pd_data  <= '0;
         r_pd_dp    <= '0;
         r_pd_blank <= '0;
         r_sh_data  <= '0;
         r_sh_dp    <= '0;
         r_sh_blank <= '0;
         r_an       <= AN_IDLE;
         r_seg      <= SEG_IDLE;
         r_dp       <= DP_IDLE;
      end else begin
         r_state <= w_state;
         r_pre   <= w_pre;
         r_dead  <= w_dead;
         r_idx   <= w_idx;
         r_frame <= w_adv0;
         if (load) begin
            r_pd_data  <= data;
            r_pd_dp    <= dp_in;
            r_pd_blank <= blank_in;
         end
         // A load coinciding with the frame boundary bypasses pending.
         if (w_adv0) begin
            r_sh_data  <= load ? data     : r_pd_data;
            r_sh_dp    <= load ? dp_in    : r_pd_dp;
            r_sh_blank <= load ? blank_in : r_pd_blank;
         end
         r_an  <= w_lit ? (w_onehot ^ AN_IDLE) : AN_IDLE;
         r_seg <= w_lit ? (w_seg ^ SEG_IDLE)   : SEG_IDLE;
         r_dp  <= w_lit ? (w_sel_dp ^ DP_IDLE) : DP_IDLE;
      end
   end

   assign an          = r_an;
   assign seg         = r_seg;
   assign dp          = r_dp;
   assign digit_idx   = r_idx;
   assign frame_start = r_frame;

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Directed bench for ssd_mux_driver: 4 digits, 4-cycle lit, 2 dead cycles,
// with a second instance built for active-low pins.
module tb_ssd_mux_driver;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;
   logic load;
   logic lzb_en;
   logic [15:0] data;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;

   logic [3:0] an;
   logic [3:0] an_n;
   logic [6:0] seg;
   logic [6:0] seg_n;
   logic       dp;
   logic       dp_n;
   logic [1:0] idx;
   logic [1:0] idx_n;
   logic       fs;
   logic       fs_n;

   int nvec = 0;
   int nerr = 0;
   int fno  = 0;

   always #5 clk = ~clk;

   ssd_mux_driver #(
      .NUM_DIGITS      (4),
      .REFRESH_DIV     (4),
      .DEAD_CYCLES     (2),
      .SEG_ACTIVE_HIGH (1'b1),
      .AN_ACTIVE_HIGH  (1'b1)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .load        (load),
      .data        (data),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .lzb_en      (lzb_en),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .digit_idx   (idx),
      .frame_start (fs)
   );

   ssd_mux_driver #(
      .NUM_DIGITS      (4),
      .REFRESH_DIV     (4),
      .DEAD_CYCLES     (2),
      .SEG_ACTIVE_HIGH (1'b0),
      .AN_ACTIVE_HIGH  (1'b0)
   ) u_inv (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .load        (load),
      .data        (data),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .lzb_en      (lzb_en),
      .an          (an_n),
      .seg         (seg_n),
      .dp          (dp_n),
      .digit_idx   (idx_n),
      .frame_start (fs_n)
   );

   function automatic logic [6:0] hexseg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;
         4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;
         4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_pins(input string tag, input logic [3:0] an_e,
                           input logic [6:0] seg_e, input logic dp_e,
                           input logic [1:0] idx_e, input logic fs_e);
      chk(tag, 32'({an, seg, dp, idx, fs}),
          32'({an_e, seg_e, dp_e, idx_e, fs_e}));
      chk({tag, "_inv"}, 32'({an_n, seg_n, dp_n, idx_n, fs_n}),
          32'({~an_e, ~seg_e, ~dp_e, idx_e, fs_e}));
   endtask

   // Starts on a frame_start sample; ends on the next one (24 cycles later).
   task automatic check_frame(input logic [15:0] dat, input logic [3:0] dpv,
                              input logic [3:0] lit, input int ld_cyc,
                              input logic [15:0] ld_dat,
                              input logic [3:0] ld_dp,
                              input logic [3:0] ld_bl);
      int  d;
      int  ph;
      logic on;
      for (int c = 1; c <= 24; c++) begin
         tick();
         d  = (c - 1) / 6;
         ph = (c - 1) % 6;
         on = (ph < 4) && lit[d];
         chk_pins($sformatf("frame%0d_cyc%0d", fno, c),
                  on ? 4'(1 << d) : 4'h0,
                  on ? hexseg(dat[4*d +: 4]) : 7'h00,
                  on & dpv[d],
                  2'((c / 6) % 4),
                  c == 24);
         if (c == ld_cyc) begin
            load     = 1'b1;
            data     = ld_dat;
            dp_in    = ld_dp;
            blank_in = ld_bl;
         end else begin
            load = 1'b0;
         end
      end
      fno++;
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b1;
      load     = 1'b0;
      lzb_en   = 1'b0;
      data     = 16'h0;
      dp_in    = 4'h0;
      blank_in = 4'h0;

      repeat (3) @(posedge clk);
      #1;
      chk_pins("reset", 4'h0, 7'h00, 1'b0, 2'd3, 1'b0);

      rst_n = 1'b1;
      load  = 1'b1;
      data  = 16'h12AF;
      tick();
      load = 1'b0;
      chk_pins("dead0", 4'h0, 7'h00, 1'b0, 2'd3, 1'b0);
      tick();
      chk_pins("first_fs", 4'h0, 7'h00, 1'b0, 2'd0, 1'b1);

      // Load mid-frame must not tear digits 2/3.
      check_frame(16'h12AF, 4'h0, 4'hF, 14, 16'h1234, 4'h0, 4'h0);
      // Load on the boundary edge shows in the frame it starts.
      check_frame(16'h1234, 4'h0, 4'hF, 23, 16'h5678, 4'h0, 4'h0);
      check_frame(16'h5678, 4'h0, 4'hF, 3, 16'h0005, 4'h0, 4'h0);

      lzb_en = 1'b1;
      check_frame(16'h0005, 4'h0, 4'b0001, 3, 16'h0005, 4'b0100, 4'h0);
      check_frame(16'h0005, 4'b0100, 4'b0111, 3, 16'h0000, 4'h0, 4'h0);
      check_frame(16'h0000, 4'h0, 4'b0001, 3, 16'h12AF, 4'h0, 4'b0010);

      lzb_en = 1'b0;
      check_frame(16'h12AF, 4'h0, 4'b1101, 3, 16'h12AF, 4'h0, 4'h0);
      check_frame(16'h12AF, 4'h0, 4'hF, -1, 16'h0, 4'h0, 4'h0);

      tick();
      tick();
      enable = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 1)
            chk_pins("en_off_lag", 4'b0001, 7'h71, 1'b0, 2'd0, 1'b0);
         else
            chk_pins($sformatf("en_off%0d", i), 4'h0, 7'h00, 1'b0, 2'd0,
                     1'b0);
      end
      enable = 1'b1;
      tick();
      chk_pins("en_dead0", 4'h0, 7'h00, 1'b0, 2'd0, 1'b0);
      tick();
      chk_pins("en_adv", 4'h0, 7'h00, 1'b0, 2'd1, 1'b0);
      tick();
      chk_pins("en_lit1", 4'b0010, 7'h77, 1'b0, 2'd1, 1'b0);
      tick();
      chk_pins("en_lit2", 4'b0010, 7'h77, 1'b0, 2'd1, 1'b0);

      rst_n = 1'b0;
      #1;
      chk_pins("async_rst", 4'h0, 7'h00, 1'b0, 2'd3, 1'b0);
      rst_n = 1'b1;
      tick();
      chk_pins("rst_dead0", 4'h0, 7'h00, 1'b0, 2'd3, 1'b0);
      tick();
      chk_pins("rst_fs", 4'h0, 7'h00, 1'b0, 2'd0, 1'b1);
      tick();
      chk_pins("rst_lit0", 4'b0001, 7'h3F, 1'b0, 2'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
